mod12_seq_checker: RTL and testbench
====================================

MOD12_SEQ_CHECKER -- requirements
Module: mod12_seq_checker

Interface
REQ-001 Parameter MOD, default 12: modulus of the monitored counter; legal count values 0..MOD-1.
REQ-002 Parameter CW, default 4: width of the count and load-data inputs.
REQ-003 Parameter WW, default 8: width of the wrap and error counters.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset; it shall be the same reset that drives the upstream counter.
REQ-006 cnt_in  in  CW  count output of the upstream loadable mod-MOD counter.
REQ-007 load_in  in  1  load strobe presented to the upstream counter.
REQ-008 data_in  in  CW  load value presented to the upstream counter.
REQ-009 clr  in  1  synchronous clear of the monitor statistics.
REQ-010 wrap  out  1  one-cycle pulse on each MOD-1 -> 0 rollover.
REQ-011 wrap_cnt  out  WW  number of rollovers, wrapping modulo 2^WW.
REQ-012 mismatch  out  1  one-cycle pulse when a sample differs from the expected value.
REQ-013 err  out  1  sticky error flag.
REQ-014 err_cnt  out  WW  mismatch count, saturating at 2^WW-1.
REQ-015 bad_load  out  1  one-cycle pulse when a load with data_in >= MOD is sampled.
REQ-016 state  out  2  FSM state: IDLE=0, TRACK=1, FAULT=2.

Function
REQ-017 At every rising edge the block shall register prev_cnt<=cnt_in, prev_load<=load_in and prev_data<=data_in.
REQ-018 The expected value shall be computed as follows:
- if prev_load=1, expected = prev_data;
- else if prev_cnt = MOD-1, expected = 0;
- otherwise, expected = prev_cnt+1 (CW-bit arithmetic).
REQ-019 A check shall take place at each rising edge in the TRACK or FAULT state: if cnt_in != expected, mismatch shall be 1 for the following cycle, otherwise 0.
REQ-020 The state machine shall have three states and the following transitions:
- IDLE: no check; go to TRACK at the next edge.
- TRACK: a mismatch moves the FSM to FAULT.
- FAULT: checking continues (it resyncs via prev_cnt each cycle); the FSM stays in FAULT until clr or rst.
REQ-021 err shall be 1 whenever state = FAULT and 0 otherwise.
REQ-022 A mismatch shall increment err_cnt by 1; err_cnt shall hold at 2^WW-1 and never wrap.
REQ-023 wrap shall be 1 for one cycle after an edge at which prev_cnt = MOD-1, prev_load = 0 and cnt_in = 0.
REQ-024 Each wrap shall increment wrap_cnt modulo 2^WW.
REQ-025 A loaded value of 0 shall never count as a wrap.
REQ-026 When load_in = 1 and data_in >= MOD are sampled at an edge, bad_load shall pulse in the next cycle.
REQ-027 The next-cycle check after a bad load (REQ-026) shall be suppressed: no mismatch, no state change, and prev registers updated normally.
REQ-028 clr = 1 at an edge shall zero wrap_cnt and err_cnt, set state = IDLE, and force wrap, mismatch and bad_load to 0.
REQ-029 clr shall take priority over a mismatch or wrap occurring at the same edge.
REQ-030 When mismatch and wrap conditions occur at the same edge, both shall be reported; the wrap condition uses only prev_* and cnt_in and is independent of expected.
REQ-031 All outputs shall be registered, with latency exactly one clock from the sampling edge.

Reset
REQ-032 While rst = 1, the block shall hold:
- state = IDLE;
- wrap = mismatch = bad_load = err = 0;
- wrap_cnt = err_cnt = 0;
- prev_cnt = 0, prev_load = 0, prev_data = 0.
REQ-033 Assertion of rst mid-operation shall clear the block immediately, regardless of clk.
REQ-034 The first edge after rst deasserts shall be spent in IDLE with no check performed.

Verification
REQ-035 Free-run from reset for 30 cycles (counter 0..11 repeating) -> wrap pulses 2 times, wrap_cnt = 2, mismatch never 1, state = TRACK.
REQ-036 Load data_in = 5 for one cycle at count 3 -> next sample is 5, then 6; no mismatch; no wrap.
REQ-037 Force cnt_in from 7 to 9 -> mismatch pulses once, err = 1, err_cnt = 1, state = FAULT; after clr -> err = 0, err_cnt = 0, state IDLE then TRACK.
REQ-038 Load data_in = 13 -> bad_load pulses once; the following sample is not checked; err remains 0.
REQ-039 Load data_in = 0 while count is 11 -> no wrap pulse and wrap_cnt unchanged.
REQ-040 Assert rst asynchronously between edges with wrap_cnt = 4 -> all outputs are 0 before the next edge; the first post-reset edge performs no check.

Source files
------------

// File: rtl/mod12_seq_checker.sv
// Watches a loadable mod-MOD counter, flags samples that break the count
// sequence, and keeps rollover and error statistics.
module mod12_seq_checker #(
  parameter int MOD = 12,
  parameter int CW  = 4,
  parameter int WW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cnt_in,
  input  logic          load_in,
  input  logic [CW-1:0] data_in,
  input  logic          clr,
  output logic          wrap,
  output logic [WW-1:0] wrap_cnt,
  output logic          mismatch,
  output logic          err,
  output logic [WW-1:0] err_cnt,
  output logic          bad_load,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST    = CW'(MOD - 1);
  localparam logic [CW:0]   MOD_EXT = (CW + 1)'(MOD);

  state_t        state_reg, state_next;
  logic [CW-1:0] prev_cnt_reg, prev_data_reg;
  logic          prev_load_reg;
  logic          wrap_reg, wrap_next;
  logic          mismatch_reg, mismatch_next;
  logic          bad_load_reg, bad_load_next;
  logic          err_reg, err_next;
  logic [WW-1:0] wrap_cnt_reg, wrap_cnt_next;
  logic [WW-1:0] err_cnt_reg, err_cnt_next;

  logic [CW-1:0] expected;
  logic          suppress;
  logic          data_bad;

  always_comb begin
    expected = '0;
    if (prev_load_reg)
      expected = prev_data_reg;
    else if (prev_cnt_reg != LAST)
      expected = prev_cnt_reg + CW'(1);
    // a rejected load leaves the upstream value unknowable for one sample
    suppress = prev_load_reg && ({1'b0, prev_data_reg} >= MOD_EXT);
    data_bad = {1'b0, data_in} >= MOD_EXT;
  end

  always_comb begin
    state_next    = state_reg;
    wrap_next     = 1'b0;
    mismatch_next = 1'b0;
    bad_load_next = 1'b0;
    wrap_cnt_next = wrap_cnt_reg;
    err_cnt_next  = err_cnt_reg;

    if (clr) begin
      state_next    = IDLE;
      wrap_cnt_next = '0;
      err_cnt_next  = '0;
    end else begin
      wrap_next     = (prev_cnt_reg == LAST) && !prev_load_reg && (cnt_in == '0);
      bad_load_next = load_in && data_bad;
      if (wrap_next)
        wrap_cnt_next = wrap_cnt_reg + WW'(1);

      case (state_reg)
        IDLE:    state_next = TRACK;
        TRACK, FAULT: begin
          if (!suppress && (cnt_in != expected)) begin
            mismatch_next = 1'b1;
            state_next    = FAULT;
          end
        end
        default: state_next = IDLE;
      endcase

      if (mismatch_next && (err_cnt_reg != '1))
        err_cnt_next = err_cnt_reg + WW'(1);
    end

    err_next = (state_next == FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      prev_cnt_reg  <= '0;
      prev_load_reg <= 1'b0;
      prev_data_reg <= '0;
      wrap_reg      <= 1'b0;
      mismatch_reg  <= 1'b0;
      bad_load_reg  <= 1'b0;
      err_reg       <= 1'b0;
      wrap_cnt_reg  <= '0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      prev_cnt_reg  <= cnt_in;
      prev_load_reg <= load_in;
      prev_data_reg <= data_in;
      wrap_reg      <= wrap_next;
      mismatch_reg  <= mismatch_next;
      bad_load_reg  <= bad_load_next;
      err_reg       <= err_next;
      wrap_cnt_reg  <= wrap_cnt_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  assign wrap     = wrap_reg;
  assign wrap_cnt = wrap_cnt_reg;
  assign mismatch = mismatch_reg;
  assign err      = err_reg;
  assign err_cnt  = err_cnt_reg;
  assign bad_load = bad_load_reg;
  assign state    = state_reg;

endmodule

// File: tb/tb_mod12_seq_checker.sv
// Randomized scoreboard bench for mod12_seq_checker: a behavioural model
// predicts each edge's outputs, a negedge monitor compares them.
module tb_mod12_seq_checker;
  localparam int MOD = 12;

  logic       clk;
  logic       rst;
  logic [3:0] cnt_in;
  logic       load_in;
  logic [3:0] data_in;
  logic       clr;
  logic       wrap, mismatch, err, bad_load;
  logic [7:0] wrap_cnt, err_cnt;
  logic [1:0] state;

  mod12_seq_checker #(.MOD(MOD), .CW(4), .WW(8)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .load_in(load_in),
    .data_in(data_in), .clr(clr), .wrap(wrap), .wrap_cnt(wrap_cnt),
    .mismatch(mismatch), .err(err), .err_cnt(err_cnt),
    .bad_load(bad_load), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit wrap;
    int wrap_cnt;
    bit mm;
    bit err;
    int err_cnt;
    bit bad;
    int st;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // model: "checking" starts one sample after reset/clear, "faulted" is sticky
  bit checking, faulted;
  int wraps, errs;
  int last_cnt, last_ld, last_data;
  logic [3:0] ucnt;  // value the upstream counter presents next

  task automatic model_reset();
    checking = 0; faulted = 0; wraps = 0; errs = 0;
    last_cnt = 0; last_ld = 0; last_data = 0;
  endtask

  task automatic model_edge();
    exp_t e;
    int   predicted;
    bit   skip;
    e = '0;
    if (rst) begin
      model_reset();
    end else begin
      if (last_ld != 0) predicted = last_data;
      else if (last_cnt == MOD - 1) predicted = 0;
      else predicted = (last_cnt + 1) % 16;
      skip   = (last_ld != 0) && (last_data >= MOD);
      e.wrap = (last_cnt == MOD - 1) && (last_ld == 0) && (cnt_in == 0);
      e.bad  = load_in && (data_in >= MOD);
      e.mm   = checking && !skip && (int'(cnt_in) != predicted);
      if (clr) begin
        checking = 0; faulted = 0; wraps = 0; errs = 0;
        e.wrap = 0; e.bad = 0; e.mm = 0;
      end else begin
        if (e.wrap) wraps = (wraps + 1) % 256;
        if (e.mm) begin
          faulted = 1;
          if (errs < 255) errs = errs + 1;
        end
        checking = 1;
      end
      e.wrap_cnt = wraps;
      e.err_cnt  = errs;
      e.err      = faulted;
      e.st       = !checking ? 0 : (faulted ? 2 : 1);
      last_cnt  = int'(cnt_in);
      last_ld   = int'(load_in);
      last_data = int'(data_in);
    end
    q.push_back(e);
  endtask

  // one clock: present inputs, let the edge happen, advance the upstream counter
  task automatic step(input bit ld, input int d, input bit c, input int fv = -1);
    cnt_in  = (fv >= 0) ? 4'(fv) : ucnt;
    load_in = ld;
    data_in = 4'(d);
    clr     = c;
    @(posedge clk);
    model_edge();
    if (rst) ucnt = 4'd0;
    else if (ld && d < MOD) ucnt = 4'(d);
    else if (cnt_in == 4'(MOD - 1)) ucnt = 4'd0;
    else ucnt = cnt_in + 4'd1;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input int expv);
    n_cmp++;
    if (act !== 32'(expv)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wrap",     {31'd0, wrap},     int'(e.wrap));
        chk("wrap_cnt", {24'd0, wrap_cnt}, e.wrap_cnt);
        chk("mismatch", {31'd0, mismatch}, int'(e.mm));
        chk("err",      {31'd0, err},      int'(e.err));
        chk("err_cnt",  {24'd0, err_cnt},  e.err_cnt);
        chk("bad_load", {31'd0, bad_load}, int'(e.bad));
        chk("state",    {30'd0, state},    e.st);
      end
    end
  end

  initial begin : driver
    int guard;
    rst = 1'b1; cnt_in = '0; load_in = 1'b0; data_in = '0; clr = 1'b0;
    ucnt = 4'd0;
    model_reset();
    repeat (3) step(0, 0, 0);
    rst = 1'b0;

    // free run from reset
    repeat (30) step(0, 0, 0);
    // good load of 5 at count 3
    while (ucnt != 4'd3) step(0, 0, 0);
    step(1, 5, 0);
    repeat (3) step(0, 0, 0);
    // jump 7 -> 9, then clear
    while (ucnt != 4'd7) step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0, 9);
    repeat (3) step(0, 0, 0);
    step(0, 0, 1);
    repeat (3) step(0, 0, 0);
    // illegal load of 13, with the counter continuing as if ignored
    step(1, 13, 0);
    repeat (3) step(0, 0, 0);
    // load 0 from count 11 is not a wrap
    while (ucnt != 4'd11) step(0, 0, 0);
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);

    // run to wrap_cnt = 4, then reset between edges
    guard = 0;
    while (wraps != 4 && guard < 200) begin
      step(0, 0, 0);
      guard++;
    end
    chk("reach_wrap4", 32'(wraps), 4);
    #2;
    rst = 1'b1;
    ucnt = 4'd0;
    model_reset();
    q[q.size() - 1] = '0;  // outputs must already be cleared at the next negedge
    repeat (2) step(0, 0, 0);
    rst = 1'b0;
    repeat (5) step(0, 0, 0);

    // randomized traffic, rare clears
    repeat (3000) begin
      step(($urandom % 8) == 0, int'($urandom % 16), ($urandom % 400) == 0,
           (($urandom % 10) == 0) ? int'($urandom % 16) : -1);
    end
    // dense corruption without clear, drives err_cnt into saturation
    repeat (700) begin
      step(($urandom % 16) == 0, int'($urandom % 16), 0,
           (($urandom % 2) == 0) ? int'($urandom % 16) : -1);
    end
    step(0, 0, 1);
    repeat (4) step(0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
